traffic_seq: RTL and testbench
==============================

TRAFFIC_SEQ -- requirements
Module: traffic_seq

Interface
REQ-001 SHALL have parameter T_NSG, default 7'd50, meaning NS green time in 0.1 s units.
REQ-002 SHALL have parameter T_NSY, default 7'd20, meaning NS yellow time.
REQ-003 SHALL have parameter T_EWG, default 7'd50, meaning EW green time.
REQ-004 SHALL have parameter T_EWY, default 7'd20, meaning EW yellow time.
REQ-005 SHALL have parameter T_AR, default 7'd10, meaning all-red clearance time.
REQ-006 SHALL have parameter T_WALK, default 7'd40, meaning pedestrian walk time.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port enable, input, 1 bit: run the sequence; low means hold all-red.
REQ-010 SHALL have port ped_req, input, 1 bit: pedestrian button, level or pulse.
REQ-011 SHALL have port tc_done, input, 1 bit: done from the phase timer.
REQ-012 SHALL have port tc_slot, output, 7 bits: duration of the current phase, to the timer.
REQ-013 SHALL have port tc_start, output, 1 bit: timer run; the timer clears its count while low.
REQ-014 SHALL have ports ns_light and ew_light, outputs, 3 bits each: one-hot {R,Y,G}.
REQ-015 SHALL have port walk, output, 1 bit: pedestrian walk lamp.
REQ-016 SHALL have port ped_pend, output, 1 bit: latched pedestrian request.
REQ-017 SHALL have port phase, output, 3 bits: current state encoding.
REQ-018 SHALL have port cycles, output, 16 bits: count of completed full cycles.

Function
REQ-019 States SHALL be OFF=0, NSG=1, NSY=2, AR1=3, EWG=4, EWY=5, AR2=6, WALK=7.
REQ-020 Transitions on a phase end SHALL be: NSG->NSY->AR1->EWG->EWY->AR2; from AR2, go to WALK if ped_pend, else NSG; WALK->NSG.
REQ-021 Lights SHALL be: NSG ns=G ew=R; NSY ns=Y ew=R; EWG ns=R ew=G; EWY ns=R ew=Y; all other states R/R; walk=1 only in WALK.
REQ-022 Each phase SHALL begin with exactly one arm cycle with tc_start=0, followed by run cycles with tc_start=1.
REQ-023 The phase SHALL end on the edge where tc_done=1 and tc_start=1. The next cycle is the new state's arm cycle.
REQ-024 Phase occupancy SHALL be 1 + (tc_slot*CLK_FREQ/10) cycles.
REQ-025 tc_done SHALL be ignored while tc_start=0.
REQ-026 tc_slot SHALL equal the current state's parameter, registered, and stable for the whole phase; OFF drives 0.
REQ-027 A parameter value of 0 SHALL be driven as 7'd1, because a zero slot never completes.
REQ-028 ped_pend SHALL set on any cycle with ped_req=1, and clear on the edge that enters WALK.
REQ-029 If ped_req=1 on the edge that enters WALK, the clear SHALL win, because the request is served by that walk.
REQ-030 enable=0, sampled at any edge, SHALL move the block to OFF on the next cycle.
REQ-031 In OFF: tc_start=0 and lights R/R. ped_pend is retained.
REQ-032 enable rising SHALL go OFF->NSG, starting with an arm cycle.
REQ-033 cycles SHALL increment by 1 on each AR2->NSG or WALK->NSG transition, wrapping at 16'hFFFF->0.

Reset
REQ-034 While RST=0, the block SHALL be forced immediately, without waiting for a clock edge, to: phase=OFF, tc_start=0, tc_slot=0, ns_light=ew_light=3'b100, walk=0, ped_pend=0, cycles=0.
REQ-035 After RST deasserts with enable=1, the first edge SHALL enter NSG (arm cycle).

Verification
REQ-036 Bench SHALL pair the block with a phase timer at CLK_FREQ=10, so a slot of N gives N run cycles. Parameters SHALL be NSG=5, NSY=2, AR=1, EWG=4, EWY=2, WALK=3.
REQ-037 Case: reset, then enable=1 with no ped_req -> NSG 6 cycles, NSY 3, AR1 2, EWG 5, EWY 3, AR2 2, then NSG; cycles=1 after the 21-cycle loop.
REQ-038 Case: ped_req 1-cycle pulse during EWG -> ped_pend=1 until AR2 ends, WALK lasts 4 cycles with walk=1 and R/R, then NSG; ped_pend=0; cycles increments on WALK->NSG.
REQ-039 Case: ped_req held high across the WALK entry edge -> ped_pend=0 in the first WALK cycle, and set again on the next cycle.
REQ-040 Case: enable=0 mid-EWG -> next cycle phase=OFF, tc_start=0, R/R; enable=1 -> NSG arm cycle; tc_done pulses while OFF are ignored.
REQ-041 Case: RST low mid-NSY -> outputs take reset values immediately, without a clock edge; cycles=0.
REQ-042 Case: one parameter set to 0 -> tc_slot=1 for that phase and the sequence continues; cycles counter forced to 16'hFFFF then one loop -> wraps to 0.

Source files
------------

// File: rtl/traffic_seq.sv
// Traffic-light phase sequencer: NS/EW green-yellow phases with all-red clearance
// and an optional pedestrian walk phase, paced by an external phase timer.
module traffic_seq #(
   parameter logic [6:0] T_NSG  = 7'd50,
   parameter logic [6:0] T_NSY  = 7'd20,
   parameter logic [6:0] T_EWG  = 7'd50,
   parameter logic [6:0] T_EWY  = 7'd20,
   parameter logic [6:0] T_AR   = 7'd10,
   parameter logic [6:0] T_WALK = 7'd40,
   localparam int unsigned SLOT_W = 7,
   localparam int unsigned LAMP_W = 3,
   localparam int unsigned PH_W   = 3,
   localparam int unsigned CYC_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              enable,
   input  logic              ped_req,
   input  logic              tc_done,
   output logic [SLOT_W-1:0] tc_slot,
   output logic              tc_start,
   output logic [LAMP_W-1:0] ns_light,
   output logic [LAMP_W-1:0] ew_light,
   output logic              walk,
   output logic              ped_pend,
   output logic [PH_W-1:0]   phase,
   output logic [CYC_W-1:0]  cycles
);

   typedef enum logic [PH_W-1:0] {
      S_OFF  = 3'd0,
      S_NSG  = 3'd1,
      S_NSY  = 3'd2,
      S_AR1  = 3'd3,
      S_EWG  = 3'd4,
      S_EWY  = 3'd5,
      S_AR2  = 3'd6,
      S_WALK = 3'd7
   } state_e;

   localparam logic [LAMP_W-1:0] LAMP_R = 3'b100;
   localparam logic [LAMP_W-1:0] LAMP_Y = 3'b010;
   localparam logic [LAMP_W-1:0] LAMP_G = 3'b001;

   // A zero slot would never let the timer finish, so it is promoted to one tick.
   localparam logic [SLOT_W-1:0] SLOT_NSG  = (T_NSG  == 7'd0) ? 7'd1 : T_NSG;
   localparam logic [SLOT_W-1:0] SLOT_NSY  = (T_NSY  == 7'd0) ? 7'd1 : T_NSY;
   localparam logic [SLOT_W-1:0] SLOT_EWG  = (T_EWG  == 7'd0) ? 7'd1 : T_EWG;
   localparam logic [SLOT_W-1:0] SLOT_EWY  = (T_EWY  == 7'd0) ? 7'd1 : T_EWY;
   localparam logic [SLOT_W-1:0] SLOT_AR   = (T_AR   == 7'd0) ? 7'd1 : T_AR;
   localparam logic [SLOT_W-1:0] SLOT_WALK = (T_WALK == 7'd0) ? 7'd1 : T_WALK;

   state_e              state_q, state_d;
   logic                tc_start_q, tc_start_d;
   logic [SLOT_W-1:0]   tc_slot_q, tc_slot_d;
   logic [LAMP_W-1:0]   ns_q, ns_d;
   logic [LAMP_W-1:0]   ew_q, ew_d;
   logic                walk_q, walk_d;
   logic                pend_q, pend_d;
   logic [CYC_W-1:0]    cycles_q, cycles_d;
   logic                phase_end;

   // State and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_OFF;
         tc_start_q <= 1'b0;
         tc_slot_q  <= '0;
         ns_q       <= LAMP_R;
         ew_q       <= LAMP_R;
         walk_q     <= 1'b0;
         pend_q     <= 1'b0;
         cycles_q   <= '0;
      end else begin
         state_q    <= state_d;
         tc_start_q <= tc_start_d;
         tc_slot_q  <= tc_slot_d;
         ns_q       <= ns_d;
         ew_q       <= ew_d;
         walk_q     <= walk_d;
         pend_q     <= pend_d;
         cycles_q   <= cycles_d;
      end
   end

   assign phase_end = tc_start_q & tc_done;

   // Next state, timer run flag, pedestrian latch and cycle counter.
   always_comb begin
      state_d    = state_q;
      tc_start_d = 1'b0;
      pend_d     = pend_q | ped_req;
      cycles_d   = cycles_q;

      if (!enable) begin
         state_d = S_OFF;
      end else begin
         case (state_q)
            S_OFF:  state_d = S_NSG;
            S_NSG:  if (phase_end) state_d = S_NSY;
            S_NSY:  if (phase_end) state_d = S_AR1;
            S_AR1:  if (phase_end) state_d = S_EWG;
            S_EWG:  if (phase_end) state_d = S_EWY;
            S_EWY:  if (phase_end) state_d = S_AR2;
            S_AR2:  if (phase_end) state_d = pend_q ? S_WALK : S_NSG;
            S_WALK: if (phase_end) state_d = S_NSG;
            default: state_d = S_OFF;
         endcase
      end

      // Any state change opens with a single arm cycle that holds the timer clear.
      tc_start_d = (state_d == state_q) && (state_q != S_OFF);

      // The walk being entered serves any request seen on the same edge.
      if ((state_d == S_WALK) && (state_q != S_WALK)) begin
         pend_d = 1'b0;
      end

      if ((state_d == S_NSG) && ((state_q == S_AR2) || (state_q == S_WALK))) begin
         cycles_d = cycles_q + CYC_W'(1);
      end
   end

   // Phase-dependent outputs, decoded from the state being entered.
   always_comb begin
      tc_slot_d = '0;
      ns_d      = LAMP_R;
      ew_d      = LAMP_R;
      walk_d    = 1'b0;
      case (state_d)
         S_NSG:  begin tc_slot_d = SLOT_NSG;  ns_d = LAMP_G; end
         S_NSY:  begin tc_slot_d = SLOT_NSY;  ns_d = LAMP_Y; end
         S_AR1:  tc_slot_d = SLOT_AR;
         S_EWG:  begin tc_slot_d = SLOT_EWG;  ew_d = LAMP_G; end
         S_EWY:  begin tc_slot_d = SLOT_EWY;  ew_d = LAMP_Y; end
         S_AR2:  tc_slot_d = SLOT_AR;
         S_WALK: begin tc_slot_d = SLOT_WALK; walk_d = 1'b1; end
         default: tc_slot_d = '0;
      endcase
   end

   assign tc_slot  = tc_slot_q;
   assign tc_start = tc_start_q;
   assign ns_light = ns_q;
   assign ew_light = ew_q;
   assign walk     = walk_q;
   assign ped_pend = pend_q;
   assign phase    = state_q;
   assign cycles   = cycles_q;

endmodule

// File: tb/tb_traffic_seq.sv
// Bench for traffic_seq: phase-timer model, per-phase segment scoreboard,
// directed pedestrian/enable/reset scenarios and a zero-slot instance.
module tb_traffic_seq;

   localparam logic [2:0] P_OFF = 3'd0, P_NSG = 3'd1, P_NSY = 3'd2, P_AR1 = 3'd3;
   localparam logic [2:0] P_EWG = 3'd4, P_EWY = 3'd5, P_AR2 = 3'd6, P_WALK = 3'd7;

   typedef struct {
      logic [2:0]  ph;
      int          len;
      logic [2:0]  ns;
      logic [2:0]  ew;
      logic        wk;
      logic [6:0]  slot;
      logic [15:0] cyc;
   } seg_t;

   logic        clk = 1'b0;
   logic        rst_n, enable, ped_req, inj_done;
   logic        tc_done, tc_start, walk, ped_pend;
   logic [6:0]  tc_slot, tcnt;
   logic [2:0]  ns_light, ew_light, phase;
   logic [15:0] cycles;

   logic        rst_z, en_z, ped_z, tc_done_z, tc_start_z, walk_z, pend_z;
   logic [6:0]  tc_slot_z, tcnt_z;
   logic [2:0]  ns_z, ew_z, ph_z;
   logic [15:0] cycles_z;
   logic        zdone;

   int   n_checks = 0;
   int   n_fail   = 0;
   seg_t expq[$];

   logic [2:0]  cur_ph, cur_ns, cur_ew;
   logic [6:0]  cur_slot;
   logic [15:0] cur_cyc;
   logic        cur_wk, cur_ts_bad, seg_open;
   int          cur_len, segn;

   always #5 clk = ~clk;

   traffic_seq #(.T_NSG(7'd5), .T_NSY(7'd2), .T_EWG(7'd4), .T_EWY(7'd2),
                 .T_AR(7'd1), .T_WALK(7'd3)) dut (
      .CLK(clk), .RST(rst_n), .enable(enable), .ped_req(ped_req), .tc_done(tc_done),
      .tc_slot(tc_slot), .tc_start(tc_start), .ns_light(ns_light), .ew_light(ew_light),
      .walk(walk), .ped_pend(ped_pend), .phase(phase), .cycles(cycles));

   traffic_seq #(.T_NSG(7'd5), .T_NSY(7'd2), .T_EWG(7'd4), .T_EWY(7'd2),
                 .T_AR(7'd0), .T_WALK(7'd3)) dut_z (
      .CLK(clk), .RST(rst_z), .enable(en_z), .ped_req(ped_z), .tc_done(tc_done_z),
      .tc_slot(tc_slot_z), .tc_start(tc_start_z), .ns_light(ns_z), .ew_light(ew_z),
      .walk(walk_z), .ped_pend(pend_z), .phase(ph_z), .cycles(cycles_z));

   // Phase timers at CLK_FREQ=10: a slot of N finishes on the Nth run cycle.
   always_ff @(posedge clk) tcnt   <= tc_start   ? tcnt + 7'd1   : 7'd0;
   always_ff @(posedge clk) tcnt_z <= tc_start_z ? tcnt_z + 7'd1 : 7'd0;
   assign tc_done   = (tc_start && (tcnt == tc_slot - 7'd1)) || inj_done;
   assign tc_done_z = tc_start_z && (tcnt_z == tc_slot_z - 7'd1);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [2:0] exp_ns(input logic [2:0] p);
      case (p)
         P_NSG:   return 3'b001;
         P_NSY:   return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_ew(input logic [2:0] p);
      case (p)
         P_EWG:   return 3'b001;
         P_EWY:   return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [6:0] exp_slot(input logic [2:0] p);
      case (p)
         P_NSG:        return 7'd5;
         P_NSY, P_EWY: return 7'd2;
         P_AR1, P_AR2: return 7'd1;
         P_EWG:        return 7'd4;
         P_WALK:       return 7'd3;
         default:      return 7'd0;
      endcase
   endfunction

   task automatic push(input logic [2:0] p, input int len, input logic [15:0] cyc);
      seg_t e;
      e.ph = p; e.len = len; e.cyc = cyc;
      e.ns = exp_ns(p); e.ew = exp_ew(p); e.wk = (p == P_WALK); e.slot = exp_slot(p);
      expq.push_back(e);
   endtask

   task automatic push_loop(input logic [15:0] cyc, input bit with_walk);
      push(P_NSG, 6, cyc); push(P_NSY, 3, cyc); push(P_AR1, 2, cyc);
      push(P_EWG, 5, cyc); push(P_EWY, 3, cyc); push(P_AR2, 2, cyc);
      if (with_walk) push(P_WALK, 4, cyc);
   endtask

   task automatic wait_ph(input logic [2:0] p, input bit on_z);
      int n = 0;
      @(negedge clk);
      while (((on_z ? ph_z : phase) !== p) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if ((on_z ? ph_z : phase) !== p) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_phase%0d_z%0d: phase %0d after 100 cycles, required %0d",
                  p, on_z, on_z ? ph_z : phase, p);
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_phase"}, 32'(phase), 32'(P_OFF));
      chk({pfx, "_tc_start"}, 32'(tc_start), 32'd0);
      chk({pfx, "_tc_slot"}, 32'(tc_slot), 32'd0);
      chk({pfx, "_ns"}, 32'(ns_light), 32'(3'b100));
      chk({pfx, "_ew"}, 32'(ew_light), 32'(3'b100));
      chk({pfx, "_walk"}, 32'(walk), 32'd0);
      chk({pfx, "_pend"}, 32'(ped_pend), 32'd0);
      chk({pfx, "_cycles"}, 32'(cycles), 32'd0);
   endtask

   task automatic close_seg();
      seg_t e;
      segn++;
      if (expq.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL seg%0d_unexpected: got phase %0d len %0d, required no segment",
                  segn, cur_ph, cur_len);
      end else begin
         e = expq.pop_front();
         chk($sformatf("seg%0d_phase", segn), 32'(cur_ph), 32'(e.ph));
         chk($sformatf("seg%0d_len_ph%0d", segn, e.ph), 32'(cur_len), 32'(e.len));
         chk($sformatf("seg%0d_ns", segn), 32'(cur_ns), 32'(e.ns));
         chk($sformatf("seg%0d_ew", segn), 32'(cur_ew), 32'(e.ew));
         chk($sformatf("seg%0d_walk", segn), 32'(cur_wk), 32'(e.wk));
         chk($sformatf("seg%0d_slot", segn), 32'(cur_slot), 32'(e.slot));
         chk($sformatf("seg%0d_cycles", segn), 32'(cur_cyc), 32'(e.cyc));
         chk($sformatf("seg%0d_tc_start_shape", segn), 32'(cur_ts_bad), 32'd0);
      end
   endtask

   // Monitor: one record per phase occupancy, closed when the phase changes.
   initial begin
      seg_open = 1'b0;
      segn     = 0;
      forever begin
         @(negedge clk);
         if (seg_open && phase === cur_ph) begin
            cur_len++;
            if (tc_start !== (cur_ph != P_OFF)) cur_ts_bad = 1'b1;
            if (tc_slot !== cur_slot) cur_ts_bad = 1'b1;
         end else begin
            if (seg_open) close_seg();
            cur_ph     = phase;
            cur_len    = 1;
            cur_ns     = ns_light;
            cur_ew     = ew_light;
            cur_wk     = walk;
            cur_slot   = tc_slot;
            cur_cyc    = cycles;
            cur_ts_bad = (tc_start !== 1'b0);
            seg_open   = 1'b1;
         end
      end
   end

   // Zero-slot instance: AR phases run with a one-tick slot and the loop completes.
   initial begin
      int l = 0;
      zdone = 1'b0; rst_z = 1'b0; en_z = 1'b1; ped_z = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_z = 1'b1;
      wait_ph(P_AR1, 1'b1);
      chk("z_ar1_slot", 32'(tc_slot_z), 32'd1);
      chk("z_ar1_lights", 32'({ns_z, ew_z}), 32'(6'b100100));
      while (ph_z === P_AR1 && l < 20) begin
         l++;
         @(negedge clk);
      end
      chk("z_ar1_len", 32'(l), 32'd2);
      wait_ph(P_AR2, 1'b1);
      chk("z_ar2_slot", 32'(tc_slot_z), 32'd1);
      wait_ph(P_NSG, 1'b1);
      chk("z_cycles", 32'(cycles_z), 32'd1);
      chk("z_walk_pend", 32'({walk_z, pend_z}), 32'd0);
      zdone = 1'b1;
   end

   initial begin
      int n = 0;
      rst_n = 1'b0; enable = 1'b1; ped_req = 1'b0; inj_done = 1'b0;

      // Reset, then one plain loop.
      push(P_OFF, 3, 16'd0);
      push_loop(16'd0, 1'b0);
      repeat (3) @(posedge clk);
      #2 chk_reset("init");
      rst_n = 1'b1;

      // Single-cycle pedestrian pulse during EWG.
      push_loop(16'd1, 1'b1);
      wait_ph(P_AR2, 1'b0);
      wait_ph(P_NSG, 1'b0);
      wait_ph(P_EWG, 1'b0);
      @(posedge clk); #2 ped_req = 1'b1;
      @(posedge clk); #2 ped_req = 1'b0;
      chk("pulse_pend_set", 32'(ped_pend), 32'd1);
      wait_ph(P_AR2, 1'b0);
      chk("pulse_pend_ar2", 32'(ped_pend), 32'd1);
      @(negedge clk);
      chk("pulse_pend_ar2_last", 32'(ped_pend), 32'd1);
      wait_ph(P_WALK, 1'b0);
      chk("pulse_pend_walk", 32'(ped_pend), 32'd0);

      // Request held across the WALK entry edge.
      push_loop(16'd2, 1'b1);
      wait_ph(P_NSG, 1'b0);
      @(posedge clk); #2 ped_req = 1'b1;
      wait_ph(P_WALK, 1'b0);
      chk("held_pend_walk_entry", 32'(ped_pend), 32'd0);
      @(negedge clk);
      chk("held_pend_reset", 32'(ped_pend), 32'd1);
      @(posedge clk); #2 ped_req = 1'b0;

      // enable dropped mid-EWG, timer done pulses while OFF.
      push(P_NSG, 6, 16'd3); push(P_NSY, 3, 16'd3); push(P_AR1, 2, 16'd3);
      push(P_EWG, 2, 16'd3); push(P_OFF, 3, 16'd3);
      push_loop(16'd3, 1'b1);
      wait_ph(P_NSG, 1'b0);
      wait_ph(P_EWG, 1'b0);
      @(posedge clk); #2 enable = 1'b0;
      @(posedge clk); #2;
      chk("off_phase", 32'(phase), 32'(P_OFF));
      chk("off_tc_start", 32'(tc_start), 32'd0);
      chk("off_lights", 32'({ns_light, ew_light}), 32'(6'b100100));
      chk("off_pend_kept", 32'(ped_pend), 32'd1);
      inj_done = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      chk("off_done_ignored", 32'(phase), 32'(P_OFF));
      inj_done = 1'b0;
      enable   = 1'b1;
      @(posedge clk); #2;
      chk("en_arm_phase", 32'(phase), 32'(P_NSG));
      chk("en_arm_tc_start", 32'(tc_start), 32'd0);

      // Asynchronous reset in the middle of NSY.
      push(P_NSG, 6, 16'd4); push(P_NSY, 1, 16'd4); push(P_OFF, 3, 16'd0);
      wait_ph(P_WALK, 1'b0);
      wait_ph(P_NSG, 1'b0);
      chk("cycles_after_walk", 32'(cycles), 32'd4);
      @(posedge clk); #2 ped_req = 1'b1;
      @(posedge clk); #2 ped_req = 1'b0;
      wait_ph(P_NSY, 1'b0);
      chk("pend_before_rst", 32'(ped_pend), 32'd1);
      @(posedge clk); #2 rst_n = 1'b0;
      #1 chk_reset("midrst");
      @(posedge clk); #2;
      @(posedge clk); #2 rst_n = 1'b1;

      // Counter wrap from 16'hFFFF.
      push(P_NSG, 6, 16'd0);   push(P_NSY, 3, 16'hFFFF); push(P_AR1, 2, 16'hFFFF);
      push(P_EWG, 5, 16'hFFFF); push(P_EWY, 3, 16'hFFFF); push(P_AR2, 2, 16'hFFFF);
      wait_ph(P_NSG, 1'b0);
      @(posedge clk); #2 force dut.cycles_q = 16'hFFFF;
      @(posedge clk); #2 release dut.cycles_q;
      chk("forced_cycles", 32'(cycles), 32'hFFFF);
      wait_ph(P_AR2, 1'b0);
      chk("cycles_pre_wrap", 32'(cycles), 32'hFFFF);
      wait_ph(P_NSG, 1'b0);
      chk("cycles_wrap", 32'(cycles), 32'd0);
      repeat (2) @(negedge clk);
      chk("queue_drained", 32'(expq.size()), 32'd0);

      while (!zdone && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("z_finished", 32'(zdone), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
